// File: rtl/sap_datapath.sv
// SAP-style 8-bit datapath: PC, MAR, MDR, RAM, IR, A, B, ALU, OUT on one bus.
// Optional flags build: define DATAPATH_FLAGS_EN for carry/zero registers.
module sap_datapath #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [14:0]       ctrl,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [DATA_W-1:0] prog_data,
  output logic [3:0]        opcode,
  output logic [DATA_W-1:0] out_val,
  output logic [DATA_W-1:0] bus_dbg,
  output logic              bus_err,
  output logic              carry,
  output logic              zero
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [ADDR_W-1:0] pc, mar;
  logic [DATA_W-1:0] mdr, ir, a, b, out_q;
  logic [DATA_W-1:0] ram [DEPTH];
  logic [DATA_W-1:0] bus, alu;
  logic [DATA_W:0]   sum;
  logic [4:0]        drv;
  logic              multi;

  logic pc_inc, pc_en, pc_load, mar_ld, mdr_ld, ram_en, ram_ld;
  logic ir_ld, ir_en, a_ld, a_en, sub, alu_en, b_ld, out_ld;

  assign pc_inc  = ctrl[14];
  assign pc_en   = ctrl[13];
  assign pc_load = ctrl[12];
  assign mar_ld  = ~ctrl[11];
  assign mdr_ld  = ~ctrl[10];
  assign ram_en  = ~ctrl[9];
  assign ram_ld  = ~ctrl[8];
  assign ir_ld   = ~ctrl[7];
  assign ir_en   = ~ctrl[6];
  assign a_ld    = ~ctrl[5];
  assign a_en    = ctrl[4];
  assign sub     = ctrl[3];
  assign alu_en  = ctrl[2];
  assign b_ld    = ~ctrl[1];
  assign out_ld  = ~ctrl[0];

  // Subtract as A + ~B + 1 so carry-out means "no borrow".
  assign sum = {1'b0, a}
             + {1'b0, (sub ? ~b : b)}
             + {{DATA_W{1'b0}}, sub};
  assign alu = sum[DATA_W-1:0];

  // Contending drivers OR together rather than fight.
  always_comb begin
    bus = '0;
    if (pc_en)  bus = bus | {{(DATA_W-ADDR_W){1'b0}}, pc};
    if (ram_en) bus = bus | ram[mar];
    if (ir_en)  bus = bus | {{(DATA_W-4){1'b0}}, ir[3:0]};
    if (a_en)   bus = bus | a;
    if (alu_en) bus = bus | alu;
  end

  assign drv   = {pc_en, ram_en, ir_en, a_en, alu_en};
  assign multi = (drv & (drv - 5'd1)) != 5'd0;

  // Program loader owns the RAM port whenever it strobes.
  always_ff @(posedge clk) begin
    if (prog_we)
      ram[prog_addr] <= prog_data;
    else if (!rst && ram_ld)
      ram[mar] <= mdr;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc      <= '0;
      mar     <= '0;
      mdr     <= '0;
      ir      <= '0;
      a       <= '0;
      b       <= '0;
      out_q   <= '0;
      bus_err <= 1'b0;
    end else begin
      if (pc_load)     pc <= bus[ADDR_W-1:0];
      else if (pc_inc) pc <= pc + 1'b1;
      if (mar_ld) mar   <= bus[ADDR_W-1:0];
      if (mdr_ld) mdr   <= bus;
      if (ir_ld)  ir    <= bus;
      if (a_ld)   a     <= bus;
      if (b_ld)   b     <= bus;
      if (out_ld) out_q <= bus;
      if (multi)  bus_err <= 1'b1;
    end
  end

`ifdef DATAPATH_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      carry <= 1'b0;
      zero  <= 1'b0;
    end else if (alu_en && a_ld) begin
      carry <= sum[DATA_W];
      zero  <= (alu == '0);
    end
  end
`else
  logic unused_carry;
  assign unused_carry = sum[DATA_W];
  assign carry = 1'b0;
  assign zero  = 1'b0;
`endif

  assign opcode  = ir[DATA_W-1:DATA_W-4];
  assign out_val = out_q;
  assign bus_dbg = bus;

endmodule
